// File: rtl/hex_display_scanner.sv
// hex_display_scanner: multiplexes one seven-segment decoder across NUM_DIGITS common-anode digits
//   clk, reset_n (async, active-low); load/value: request a new displayed value;
//   blank_lz: suppress leading zeros; seg (active-low a..g), digit_en (active-low one-hot);
//   pending: a loaded value is waiting for the frame boundary; frame_done: one-cycle pulse per frame.
module seven_seg_decoder (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end
endmodule

module hex_display_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    pending,
  output logic                    frame_done
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  typedef enum logic {BLANK, DRIVE} state_t;
  state_t                  state, state_nx;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] shadow, active;
  logic                    lz, slot_end, blank_end, idx_last, supp;
  logic [3:0]              nib;
  logic [6:0]              dec;
  seven_seg_decoder u_dec (.hex(nib), .seg(dec));
  always_comb begin
    slot_end  = cnt == CW'(SCAN_DIV - 1);
    blank_end = cnt == CW'(BLANK_CYC - 1);
    idx_last  = idx == IW'(NUM_DIGITS - 1);
    nib       = 4'(active >> {idx, 2'b00});
    // everything from this digit upward is zero; digit 0 always shows
    supp      = lz && idx != '0 && (active >> {idx, 2'b00}) == '0;
    state_nx  = state == BLANK ? (blank_end ? DRIVE : BLANK) : (slot_end ? BLANK : DRIVE);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      lz         <= 1'b0;
      shadow     <= '0;
      active     <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      seg        <= 7'h7F;
      digit_en   <= '1;
    end else begin
      state      <= state_nx;
      cnt        <= slot_end ? '0 : cnt + 1'b1;
      if (state == DRIVE && slot_end) idx <= idx_last ? '0 : idx + 1'b1;
      if (state == BLANK && blank_end) lz <= blank_lz;
      frame_done <= state == DRIVE && slot_end && idx_last;
      // frame_done marks the boundary cycle; the commit lands while the first slot is still blanked
      if (load) shadow <= value;
      if (frame_done && pending) active <= shadow;
      pending    <= load || (pending && !frame_done);
      seg        <= state == DRIVE && !supp ? dec : 7'h7F;
      digit_en   <= state == DRIVE ? ~(NUM_DIGITS'(1) << idx) : '1;
    end
  end
endmodule

// File: tb/tb_hex_display_scanner.sv
// tb_hex_display_scanner: directed checks of scanning, load/commit, blanking and reset
module tb_hex_display_scanner;
  logic        clk, reset_n, load, blank_lz;
  logic [15:0] value;
  logic [6:0]  seg;
  logic [3:0]  digit_en;
  logic        pending, frame_done;
  int          errors = 0, checks = 0, j = 0;

  hex_display_scanner #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .value(value), .blank_lz(blank_lz),
    .seg(seg), .digit_en(digit_en), .pending(pending), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    j++;
  endtask

  // digit shown in cycle c after reset release, -1 while blanked
  function automatic int exp_dig(int c);
    if (c % 8 >= 3) return (c / 8) % 4;
    if (c % 8 == 0 && c >= 8) return (c / 8 - 1) % 4;
    return -1;
  endfunction

  function automatic logic [6:0] seg_of(logic [3:0] h);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[h];
  endfunction

  function automatic logic [6:0] exp_seg(logic [15:0] v, int d, bit lzb);
    if (d < 0) return 7'h7F;
    if (lzb && d > 0 && (v >> (4 * d)) == 16'h0) return 7'h7F;
    return seg_of(v[4*d +: 4]);
  endfunction

  function automatic logic [3:0] exp_en(int d);
    return d < 0 ? 4'hF : ~(4'b0001 << d);
  endfunction

  task automatic test_reset();
    reset_n = 1'b1; load = 1'b0; blank_lz = 1'b0; value = 16'h0;
    #3 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%h exp=7f", seg); end
    if (digit_en !== 4'hF) begin errors++; $display("FAIL reset_en got=%b exp=1111", digit_en); end
    if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending got=%b exp=0", pending); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    j = 0;
  endtask

  task automatic test_idle_scan();
    while (j < 64) begin
      tick();
      checks += 3;
      if (digit_en !== exp_en(exp_dig(j))) begin errors++; $display("FAIL idle_en c=%0d got=%b exp=%b", j, digit_en, exp_en(exp_dig(j))); end
      if (seg !== exp_seg(16'h0, exp_dig(j), 0)) begin errors++; $display("FAIL idle_seg c=%0d got=%h exp=%h", j, seg, exp_seg(16'h0, exp_dig(j), 0)); end
      if (frame_done !== (j % 32 == 0)) begin errors++; $display("FAIL idle_fd c=%0d got=%b", j, frame_done); end
    end
  endtask

  task automatic test_load_commit();
    while (j < 70) tick();
    value = 16'h0158; load = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (pending !== 1'b1) begin errors++; $display("FAIL lc_pending_rise got=%b exp=1", pending); end
    while (j < 96) tick();
    checks += 2;
    if (pending !== 1'b1) begin errors++; $display("FAIL lc_pending_hold got=%b exp=1", pending); end
    if (frame_done !== 1'b1) begin errors++; $display("FAIL lc_fd got=%b exp=1", frame_done); end
    tick();
    checks++;
    if (pending !== 1'b0) begin errors++; $display("FAIL lc_pending_fall got=%b exp=0", pending); end
    while (j < 128) begin
      tick();
      checks += 2;
      if (digit_en !== exp_en(exp_dig(j))) begin errors++; $display("FAIL lc_en c=%0d got=%b exp=%b", j, digit_en, exp_en(exp_dig(j))); end
      if (seg !== exp_seg(16'h0158, exp_dig(j), 0)) begin errors++; $display("FAIL lc_seg c=%0d got=%h exp=%h", j, seg, exp_seg(16'h0158, exp_dig(j), 0)); end
    end
  endtask

  task automatic test_lz();
    blank_lz = 1'b1;
    while (j < 130) tick();
    value = 16'h0005; load = 1'b1;
    tick();
    load = 1'b0;
    while (j < 160) tick();
    while (j < 192) begin
      tick();
      checks++;
      if (seg !== exp_seg(16'h0005, exp_dig(j), 1)) begin errors++; $display("FAIL lz5_seg c=%0d got=%h exp=%h", j, seg, exp_seg(16'h0005, exp_dig(j), 1)); end
    end
    while (j < 194) tick();
    value = 16'h0000; load = 1'b1;
    tick();
    load = 1'b0;
    while (j < 224) tick();
    while (j < 256) begin
      tick();
      checks++;
      if (seg !== exp_seg(16'h0000, exp_dig(j), 1)) begin errors++; $display("FAIL lz0_seg c=%0d got=%h exp=%h", j, seg, exp_seg(16'h0000, exp_dig(j), 1)); end
    end
  endtask

  task automatic test_back_to_back();
    blank_lz = 1'b0;
    while (j < 258) tick();
    value = 16'h1111; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    value = 16'h2222; load = 1'b1;
    tick();
    load = 1'b0;
    while (j < 352) begin
      tick();
      checks++;
      if (seg !== exp_seg(j <= 288 ? 16'h0000 : 16'h2222, exp_dig(j), 0)) begin
        errors++; $display("FAIL b2b_seg c=%0d got=%h exp=%h", j, seg, exp_seg(j <= 288 ? 16'h0000 : 16'h2222, exp_dig(j), 0));
      end
      if (j == 289) begin
        checks++;
        if (pending !== 1'b0) begin errors++; $display("FAIL b2b_pending got=%b exp=0", pending); end
      end
    end
  endtask

  task automatic test_load_at_boundary();
    while (j < 354) tick();
    value = 16'h1111; load = 1'b1;
    tick();
    load = 1'b0;
    while (j < 384) tick();
    checks++;
    if (frame_done !== 1'b1) begin errors++; $display("FAIL lb_fd got=%b exp=1", frame_done); end
    value = 16'h8888; load = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (pending !== 1'b1) begin errors++; $display("FAIL lb_pending_stay got=%b exp=1", pending); end
    while (j < 448) begin
      tick();
      checks++;
      if (seg !== exp_seg(j <= 416 ? 16'h1111 : 16'h8888, exp_dig(j), 0)) begin
        errors++; $display("FAIL lb_seg c=%0d got=%h exp=%h", j, seg, exp_seg(j <= 416 ? 16'h1111 : 16'h8888, exp_dig(j), 0));
      end
      if (j == 417) begin
        checks++;
        if (pending !== 1'b0) begin errors++; $display("FAIL lb_pending_fall got=%b exp=0", pending); end
      end
    end
  endtask

  task automatic test_reset_mid_drive();
    while (j < 450) tick();
    value = 16'h3333; load = 1'b1;
    tick();
    load = 1'b0;
    while (j < 468) tick();
    checks += 2;
    if (digit_en !== 4'b1011) begin errors++; $display("FAIL rm_pre_en got=%b exp=1011", digit_en); end
    if (pending !== 1'b1) begin errors++; $display("FAIL rm_pre_pending got=%b exp=1", pending); end
    #1 reset_n = 1'b0;
    #1;
    checks += 3;
    if (digit_en !== 4'hF) begin errors++; $display("FAIL rm_en got=%b exp=1111", digit_en); end
    if (seg !== 7'h7F) begin errors++; $display("FAIL rm_seg got=%h exp=7f", seg); end
    if (pending !== 1'b0) begin errors++; $display("FAIL rm_pending got=%b exp=0", pending); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    j = 0;
    while (j < 12) begin
      tick();
      checks += 3;
      if (digit_en !== exp_en(exp_dig(j))) begin errors++; $display("FAIL rm_post_en c=%0d got=%b exp=%b", j, digit_en, exp_en(exp_dig(j))); end
      if (seg !== exp_seg(16'h0, exp_dig(j), 0)) begin errors++; $display("FAIL rm_post_seg c=%0d got=%h exp=%h", j, seg, exp_seg(16'h0, exp_dig(j), 0)); end
      if (pending !== 1'b0) begin errors++; $display("FAIL rm_post_pending c=%0d got=%b exp=0", j, pending); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_load_commit();
    test_lz();
    test_back_to_back();
    test_load_at_boundary();
    test_reset_mid_drive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
